// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// The mode encodings are used by the RTL and by its bench.
package barrel_shifter_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_ROL = 2'b00,
        MODE_SLL = 2'b01,
        MODE_SRL = 2'b10,
        MODE_SRA = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/barrel_shifter_pipe_stage.sv
// One combinational barrel-shifter stage.
// It shifts by a fixed DIST when en is set and passes the data through otherwise.
module barrel_shift_stage
    import barrel_shifter_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sign,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        if (en) begin
            case (mode)
                MODE_ROL: q = {d[WIDTH-1-DIST:0], d[WIDTH-1:WIDTH-DIST]};
                MODE_SLL: q = {d[WIDTH-1-DIST:0], {DIST{1'b0}}};
                MODE_SRL: q = {{DIST{1'b0}}, d[WIDTH-1:DIST]};
                // sign is the original operand MSB, not the MSB of the partial result
                MODE_SRA: q = {{DIST{sign}}, d[WIDTH-1:DIST]};
                default:  q = d;
            endcase
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready on both sides.
// Stage k shifts by 2^k, so there is one register stage per bit of the shift amount.
module barrel_shifter_pipe
    import barrel_shifter_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] data_q  [AMT_W];
    logic [AMT_W-1:0] amt_q   [AMT_W];
    logic [1:0]       mode_q  [AMT_W];
    logic             sign_q  [AMT_W];
    logic [AMT_W-1:0] valid_q;

    logic [WIDTH-1:0] stg_data  [AMT_W];
    logic [AMT_W-1:0] stg_amt   [AMT_W];
    logic [1:0]       stg_mode  [AMT_W];
    logic             stg_sign  [AMT_W];
    logic [AMT_W-1:0] stg_valid;
    logic [WIDTH-1:0] stage_q   [AMT_W];

    logic adv;

    // The whole pipe moves as one; a full output slot with no taker freezes every stage.
    assign adv       = !valid_q[AMT_W-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[AMT_W-1];
    assign out_data  = data_q[AMT_W-1];

    always_comb begin
        stg_data[0]  = in_data;
        stg_amt[0]   = in_amt;
        stg_mode[0]  = in_mode;
        stg_sign[0]  = in_data[WIDTH-1];
        stg_valid    = '0;
        stg_valid[0] = in_valid;
        for (int k = 1; k < AMT_W; k++) begin
            stg_data[k]  = data_q[k-1];
            stg_amt[k]   = amt_q[k-1];
            stg_mode[k]  = mode_q[k-1];
            stg_sign[k]  = sign_q[k-1];
            stg_valid[k] = valid_q[k-1];
        end
    end

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .d    (stg_data[k]),
            .en   (stg_amt[k][k]),
            .mode (stg_mode[k]),
            .sign (stg_sign[k]),
            .q    (stage_q[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < AMT_W; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
                sign_q[k] <= 1'b0;
            end
        end else if (adv) begin
            valid_q <= stg_valid;
            for (int k = 0; k < AMT_W; k++) begin
                data_q[k] <= stage_q[k];
                amt_q[k]  <= stg_amt[k];
                mode_q[k] <= stg_mode[k];
                sign_q[k] <= stg_sign[k];
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe: a WIDTH=4 and a WIDTH=8 instance,
// each with a scoreboard queue filled on accept and drained on output handshake.
module tb_barrel_shifter_pipe;
    import barrel_shifter_pipe_pkg::*;

    typedef struct {
        logic [7:0] exp;
        int         cyc;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    bit         lat_chk4 = 1'b0;
    bit         lat_chk8 = 1'b0;
    sb_t        q4[$];
    sb_t        q8[$];

    logic       iv4, ir4, ov4, or4;
    logic [3:0] id4, od4;
    logic [1:0] ia4, im4;

    logic       iv8, ir8, ov8, or8;
    logic [7:0] id8, od8;
    logic [2:0] ia8;
    logic [1:0] im8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    barrel_shifter_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_amt(ia4), .in_mode(im4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4)
    );

    barrel_shifter_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_amt(ia8), .in_mode(im8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8)
    );

    // Reference: whole-word arithmetic, independent of the staged decomposition.
    function automatic logic [7:0] model(int w, logic [7:0] x, int a, logic [1:0] m);
        logic [15:0] mask;
        logic [15:0] xx;
        logic [15:0] sx;
        logic [15:0] r;
        mask = (16'h1 << w) - 16'h1;
        xx   = {8'h00, x} & mask;
        case (m)
            MODE_ROL: r = (xx << a) | (xx >> (w - a));
            MODE_SLL: r = xx << a;
            MODE_SRL: r = xx >> a;
            default: begin
                sx = xx[w-1] ? (xx | ~mask) : xx;
                r  = $signed(sx) >>> a;
            end
        endcase
        r = r & mask;
        return r[7:0];
    endfunction

    always @(negedge clk) begin
        if (!rst && ov4 && or4) begin
            vectors++;
            if (q4.size() == 0) begin
                miscompares++;
                $display("FAIL out4_unexpected got=%h with empty scoreboard (cycle %0d)", od4, cyc);
            end else begin
                sb_t e;
                e = q4.pop_front();
                if (od4 !== e.exp[3:0]) begin
                    miscompares++;
                    $display("FAIL out4_data got=%h exp=%h (cycle %0d)", od4, e.exp[3:0], cyc);
                end
                if (lat_chk4) begin
                    vectors++;
                    if (cyc - e.cyc != 2) begin
                        miscompares++;
                        $display("FAIL out4_latency got=%0d exp=2", cyc - e.cyc);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov8 && or8) begin
            vectors++;
            if (q8.size() == 0) begin
                miscompares++;
                $display("FAIL out8_unexpected got=%h with empty scoreboard (cycle %0d)", od8, cyc);
            end else begin
                sb_t e;
                e = q8.pop_front();
                if (od8 !== e.exp) begin
                    miscompares++;
                    $display("FAIL out8_data got=%h exp=%h (cycle %0d)", od8, e.exp, cyc);
                end
                if (lat_chk8) begin
                    vectors++;
                    if (cyc - e.cyc != 3) begin
                        miscompares++;
                        $display("FAIL out8_latency got=%0d exp=3", cyc - e.cyc);
                    end
                end
            end
        end
    end

    task automatic send4(input logic [3:0] d, input logic [1:0] a, input logic [1:0] m,
                         input logic [3:0] exp);
        bit done;
        done = 1'b0;
        iv4 = 1'b1; id4 = d; ia4 = a; im4 = m;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (ir4) begin
                q4.push_back('{exp: {4'h0, exp}, cyc: cyc});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL send4_timeout in_ready stayed 0");
        end
    endtask

    task automatic send8(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                         input logic [7:0] exp);
        bit done;
        done = 1'b0;
        iv8 = 1'b1; id8 = d; ia8 = a; im8 = m;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (ir8) begin
                q8.push_back('{exp: exp, cyc: cyc});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL send8_timeout in_ready stayed 0");
        end
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200 && (q4.size() != 0 || q8.size() != 0); t++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        vectors++;
        if (q4.size() != 0 || q8.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain left4=%0d left8=%0d exp=0", name, q4.size(), q8.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (ov4 !== 1'b0 || od4 !== 4'h0 || ov8 !== 1'b0 || od8 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state ov4=%b od4=%h ov8=%b od8=%h exp=0", ov4, od4, ov8, od8);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (ir4 !== 1'b1 || ov4 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready ir4=%b ov4=%b exp ir4=1 ov4=0", ir4, ov4);
        end
    endtask

    task automatic test_rotate_sweep();
        logic [3:0] one;
        one = 4'h1;
        lat_chk4 = 1'b1;
        for (int a = 0; a < 4; a++) send4(one, a[1:0], MODE_ROL, one << a);
        iv4 = 1'b0;
        drain("rotate_sweep");
    endtask

    task automatic test_modes();
        lat_chk4 = 1'b1;
        send4(4'b1001, 2'd1, MODE_ROL, 4'b0011);
        send4(4'b1001, 2'd1, MODE_SLL, 4'b0010);
        send4(4'b1001, 2'd1, MODE_SRL, 4'b0100);
        send4(4'b1001, 2'd1, MODE_SRA, 4'b1100);
        send4(4'b1001, 2'd3, MODE_SRA, 4'b1111);
        send4(4'b0110, 2'd2, MODE_SRA, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            logic [1:0] a;
            logic [1:0] m;
            logic [7:0] e;
            d = 8'($urandom_range(0, 15));
            a = 2'($urandom_range(0, 3));
            m = 2'($urandom_range(0, 3));
            e = model(4, d, int'(a), m);
            send4(d[3:0], a, m, e[3:0]);
        end
        iv4 = 1'b0;
        drain("modes");
    endtask

    task automatic test_backpressure();
        int         sent;
        logic [3:0] held;
        lat_chk4 = 1'b0;
        sent = 0;
        held = '0;
        for (int c = 0; c < 40 && (sent < 6 || q4.size() != 0); c++) begin
            logic       stall;
            logic [7:0] d;
            logic [7:0] e;
            stall = (c >= 3 && c < 8);
            or4 = !stall;
            d = 8'(4'(c * 5 + 3));
            iv4 = (sent < 6);
            id4 = d[3:0]; ia4 = 2'(c); im4 = 2'(c + 1);
            @(negedge clk);
            if (stall) begin
                vectors++;
                if (ir4 !== 1'b0 || ov4 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_stall_ready ir4=%b ov4=%b exp ir4=0 ov4=1", ir4, ov4);
                end
                if (c == 3) held = od4;
                else begin
                    vectors++;
                    if (od4 !== held) begin
                        miscompares++;
                        $display("FAIL bp_stall_hold got=%h exp=%h", od4, held);
                    end
                end
            end
            if (iv4 && ir4) begin
                e = model(4, d, c % 4, 2'(c + 1));
                q4.push_back('{exp: e, cyc: cyc});
                sent++;
            end
            @(posedge clk); #1;
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        vectors++;
        if (sent != 6) begin
            miscompares++;
            $display("FAIL bp_sent got=%0d exp=6", sent);
        end
        drain("backpressure");
    endtask

    task automatic test_bubbles();
        logic [3:0] pat;
        pat = 4'b0101;
        lat_chk4 = 1'b1;
        or4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            iv4 = (i < 4) ? pat[i] : 1'b0;
            id4 = 4'(i + 6); ia4 = 2'd1; im4 = MODE_SLL;
            @(negedge clk);
            if (iv4 && ir4) q4.push_back('{exp: model(4, 8'(i + 6), 1, MODE_SLL), cyc: cyc});
            if (i >= 2) begin
                vectors++;
                if (ov4 !== pat[i-2]) begin
                    miscompares++;
                    $display("FAIL bubble_valid slot=%0d got=%b exp=%b", i - 2, ov4, pat[i-2]);
                end
            end
            @(posedge clk); #1;
        end
        iv4 = 1'b0;
        drain("bubbles");
    endtask

    task automatic test_reset_midflight();
        lat_chk4 = 1'b1;
        or4 = 1'b0;
        send4(4'h3, 2'd1, MODE_ROL, 4'h6);
        send4(4'h5, 2'd2, MODE_SLL, 4'h4);
        iv4 = 1'b0;
        vectors++;
        if (ov4 !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_inflight ov4=%b exp=1", ov4);
        end
        rst = 1'b1;
        @(negedge clk);
        q4.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        or4 = 1'b1;
        vectors++;
        if (ov4 !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_flush ov4=%b exp=0", ov4);
        end
        iv4 = 1'b1; id4 = 4'hA; ia4 = 2'd3; im4 = MODE_SRL;
        @(negedge clk);
        vectors++;
        if (ir4 !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_accept ir4=%b exp=1", ir4);
        end else begin
            q4.push_back('{exp: 8'h01, cyc: cyc});
        end
        @(posedge clk); #1;
        iv4 = 1'b0;
        drain("reset_midflight");
    endtask

    task automatic test_width8();
        lat_chk8 = 1'b1;
        or8 = 1'b1;
        send8(8'h80, 3'd7, MODE_SRA, 8'hFF);
        send8(8'h81, 3'd4, MODE_ROL, 8'h18);
        send8(8'h96, 3'd0, MODE_SRA, 8'h96);
        send8(8'h96, 3'd5, MODE_SRL, 8'h04);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            logic [2:0] a;
            logic [1:0] m;
            d = 8'($urandom);
            a = 3'($urandom_range(0, 7));
            m = 2'($urandom_range(0, 3));
            send8(d, a, m, model(8, d, int'(a), m));
        end
        iv8 = 1'b0;
        drain("width8");
    endtask

    initial begin
        iv4 = 1'b0; id4 = '0; ia4 = '0; im4 = '0; or4 = 1'b1;
        iv8 = 1'b0; id8 = '0; ia8 = '0; im8 = '0; or8 = 1'b1;
        test_reset();
        test_rotate_sweep();
        test_modes();
        test_backpressure();
        test_bubbles();
        test_reset_midflight();
        test_width8();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
